// File: rtl/st_pkt_serializer_if.sv
// Ready/valid packet stream: one data word per handshake with sop/eop framing
// and a byte count on the final word (0 means all bytes valid).
interface st_pkt_intf #(
  parameter int WIDTH = 32
);
  localparam int BYTES = WIDTH / 8;
  localparam int LEN_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic             valid;
  logic             ready;
  logic             sop;
  logic             eop;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;

  modport master (output valid, sop, eop, data, len, input ready);
  modport slave  (input valid, sop, eop, data, len, output ready);
endinterface

// File: rtl/st_pkt_serializer.sv
// Width-down converter: each wide word leaves as up to RATIO narrow beats,
// least-significant lane first, with sop/eop/len regenerated per beat.
module st_pkt_serializer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  st_pkt_intf.slave  s_in,
  st_pkt_intf.master m_out
);
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OLEN_W    = $clog2(OUT_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_beat_q, last_beat_d;
  logic [OLEN_W-1:0]   last_len_q, last_len_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;

  logic [OUT_WIDTH-1:0] lanes [RATIO];
  logic                 at_last;
  logic                 m_fire;
  logic                 s_rdy;
  logic                 s_fire;
  int unsigned          nbytes;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lanes[gi] = hold_q[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign at_last = (cnt_q == last_beat_q);
  assign m_fire  = (state_q == SEND) && m_out.ready;
  // Ready looks through to m_out.ready so the next word lands on the last beat.
  assign s_rdy   = (state_q == IDLE) || (at_last && m_out.ready);
  assign s_fire  = s_in.valid && s_rdy;
  assign nbytes  = (s_in.len == '0) ? IN_BYTES : 32'(s_in.len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_beat_q <= '0;
      last_len_q  <= '0;
      hold_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_beat_q <= last_beat_d;
      last_len_q  <= last_len_d;
      hold_q      <= hold_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_fire) state_d = SEND;
      SEND:    if (m_fire && at_last && !s_in.valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_beat_d = last_beat_q;
    last_len_d  = last_len_q;
    hold_d      = hold_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    if (s_fire) begin
      hold_d = s_in.data;
      sop_d  = s_in.sop;
      eop_d  = s_in.eop;
      cnt_d  = '0;
      // Only an eop word can be short; its byte count sets the beat count.
      if (s_in.eop) begin
        last_beat_d = CNT_W'((nbytes + OUT_BYTES - 1) / OUT_BYTES - 1);
        last_len_d  = OLEN_W'(nbytes % OUT_BYTES);
      end else begin
        last_beat_d = CNT_W'(RATIO - 1);
        last_len_d  = '0;
      end
    end else if (m_fire && !at_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    s_in.ready  = s_rdy;
    m_out.valid = (state_q == SEND);
    m_out.data  = lanes[cnt_q];
    m_out.sop   = (state_q == SEND) && sop_q && (cnt_q == '0);
    m_out.eop   = (state_q == SEND) && eop_q && at_last;
    m_out.len   = ((state_q == SEND) && at_last) ? last_len_q : '0;
  end
endmodule

// File: doc/st_pkt_serializer.md
Name: st_pkt_serializer

Overview:
- Width-down converter for the ready/valid packet stream (st_pkt_intf).
- Accepts IN_WIDTH-bit packet words and emits each one as a sequence of OUT_WIDTH-bit beats, least-significant lane first.
- Regenerates sop, eop and len on the narrow side.
- Sits between wide internal datapaths and narrow egress or serial links; it is the generalised, ratio-parametrised stage of the serializer generator.

Parameters:
- IN_WIDTH, 128, input data width in bits; multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output data width in bits; multiple of 8, >= 16.
- Derived, not overridable: RATIO = IN_WIDTH/OUT_WIDTH (>= 1); OUT_BYTES = OUT_WIDTH/8; IN_BYTES = IN_WIDTH/8.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_in  st_pkt_intf.slave  WIDTH=IN_WIDTH  wide input stream.
- m_out  st_pkt_intf.master  WIDTH=OUT_WIDTH  narrow output stream.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - m_out.valid=0, sop=0, eop=0, len=0, data=0.
  - State IDLE, beat counter 0, s_in.ready=1 after release.
  - A partial packet in flight at reset is discarded; no beat of it appears after release.
- Storage: one holding register for the wide word plus sop, eop, last_beat index and last_len. Output fields are driven from this register (registered, no combinational path from s_in to m_out).
- FSM states:
  - IDLE: nothing held.
  - SEND: holding word valid; beat counter cnt (0..RATIO-1).
- Transitions:
  - IDLE: on s_in.valid && s_in.ready, capture the word, set cnt=0, go to SEND. m_out.valid=1 on the next cycle (latency 1).
  - SEND: on m_out handshake with cnt<last_beat, cnt++.
  - SEND, on m_out handshake with cnt==last_beat:
    - if s_in.valid, capture the new word, cnt=0, stay in SEND (zero-bubble back-to-back);
    - otherwise go to IDLE, m_out.valid=0 next cycle.
- s_in.ready = (state==IDLE) || (cnt==last_beat && m_out.ready). This is combinational from m_out.ready by design.
- Beat data: m_out.data = hold[cnt*OUT_WIDTH +: OUT_WIDTH]. Byte 0 of the wide word (bits [7:0]) goes out first.
- Flags:
  - m_out.sop=1 only on beat 0 of a word captured with sop.
  - m_out.eop=1 only on beat last_beat of a word captured with eop.
- last_beat / last_len computation, where nbytes = (len==0 ? IN_BYTES : len):
  - Non-eop word: last_beat=RATIO-1 and all beats have len=0. Input len is ignored.
  - Eop word: last_beat = ceil(nbytes/OUT_BYTES)-1.
  - Final beat len = nbytes mod OUT_BYTES; value 0 means full. All other beats have len 0.
  - Beats past last_beat are never emitted.
- Valid bytes of a partial input word are its least-significant bytes. Bytes beyond len in the final output beat are don't-care.
- Hold rule: while m_out.valid && !m_out.ready, data, sop, eop and len stay stable and valid does not drop.
- A word with sop && eop together (single-word packet) is legal and produces both flags on the correct beats. Both flags land on the same beat if last_beat==0.
- RATIO==1: behaves as a one-deep registered pipeline stage with full throughput and len passed through.
- Throughput: one input word per (last_beat+1) cycles under continuous m_out.ready, with no idle cycles between words.

Test Plan:
1. Full word, IN_WIDTH=128 / OUT_WIDTH=32: sop=eop=1, len=0, data bytes 0x00..0x0F in ascending lanes -> 4 beats: 0x03020100 (sop), 0x07060504, 0x0B0A0908, 0x0F0E0D0C (eop). len=0 on every beat.
2. Short eop: 2-word packet, second word eop with len=5 -> 4+2 beats. Final beat has eop=1, len=1 and byte 4 of that word in data[7:0].
3. Aligned short eop: eop word with len=8 -> exactly 2 beats, final len=0, eop on beat 1. len=15 -> 4 beats, final len=3.
4. Backpressure: m_out.ready pattern 1,0,0,1,0,1,1 during a 4-beat word -> data and flags stable during the 0 cycles, all 4 beats in order with none lost or duplicated. s_in.ready=0 until the cycle beat 3 is accepted.
5. Streaming: three back-to-back 128-bit words (sop, mid, eop len=0), s_in.valid held high, m_out.ready=1 -> 12 consecutive valid beats with no gaps. s_in.ready high exactly on the last-beat cycles.
6. Reset mid-packet: assert rst_n=0 after beat 1 of 4 -> m_out.valid=0 immediately, without waiting for clk. After release, s_in.ready=1; the next sop word emits beat 0 with sop=1 and no stale beats.
